// File: rtl/boot_loader_pkg.sv
// boot_pkg: loader FSM states and frame layout constants.
package boot_pkg;
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} boot_state_t;
    localparam int HDR_BYTES = 2;
    localparam int CSUM_BYTES = 1;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream in, RAM write port out.
interface boot_loader_if #(parameter int ADDR_W = 11);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/boot_loader_word_packer.sv
// word_packer: shifts bytes MSB-first into 32-bit words, pulses word_valid on the 4th byte.
module word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    always_comb begin
        cnt_d = clr ? 2'd0 : byte_valid ? cnt_q + 2'd1 : cnt_q;
        sr_d  = clr ? 24'd0 : byte_valid ? {sr_q[15:0], byte_in} : sr_q;
        word_valid = byte_valid && !clr && cnt_q == 2'd3;
        word  = {sr_q, byte_in};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a framed program image, writes it to RAM, verifies
// the XOR checksum and releases the CPU from reset on a good load.
module boot_loader
    import boot_pkg::*;
#(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         load_done,
    output logic         load_err
);
    boot_state_t       state_q, state_d;
    logic              xfer, clr, byte_valid, word_valid;
    logic [31:0]       word;
    logic [15:0]       n_q, n_d, hdr_n;
    logic [16:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, cpu_reset_q, cpu_reset_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HDR_HI;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: state_d = xfer ? HDR_LO : HDR_HI;
            HDR_LO: if (xfer) state_d = {1'b0, hdr_n} > 17'(MEM_DEPTH) ? ERR : hdr_n == 16'd0 ? CSUM : DATA;
            DATA:   if (word_valid && wcnt_q + 17'd1 == {1'b0, n_q}) state_d = CSUM;
            CSUM:   if (xfer) state_d = bus.in_data == csum_q ? DONE : ERR;
            default: state_d = state_q;
        endcase
    end
    always_comb begin
        bus.in_ready = state_q inside {HDR_HI, HDR_LO, DATA, CSUM};
        load_done    = state_q == DONE;
        load_err     = state_q == ERR;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        cpu_reset     = cpu_reset_q;
    end
    // Start of a new frame (second header byte) clears packer, counters and checksum.
    assign xfer       = bus.in_valid && bus.in_ready;
    assign hdr_n      = {n_q[15:8], bus.in_data};
    assign clr        = xfer && state_q == HDR_LO;
    assign byte_valid = xfer && state_q == DATA;
    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .byte_valid(byte_valid),
        .byte_in   (bus.in_data),
        .word_valid(word_valid),
        .word      (word)
    );
    always_comb begin
        n_d         = xfer && state_q == HDR_HI ? {bus.in_data, 8'd0} : clr ? hdr_n : n_q;
        wcnt_d      = clr ? 17'd0 : word_valid ? wcnt_q + 17'd1 : wcnt_q;
        addr_d      = clr ? '0 : word_valid ? addr_q + 1'b1 : addr_q;
        csum_d      = clr ? 8'd0 : byte_valid ? csum_q ^ bus.in_data : csum_q;
        mem_we_d    = word_valid;
        mem_addr_d  = word_valid ? addr_q : mem_addr_q;
        mem_wdata_d = word_valid ? word : mem_wdata_q;
        cpu_reset_d = state_q != DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q         <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven frames with a write scoreboard, plus a reset-mid-load sequence.
module tb_boot_loader;
    typedef struct {
        int               len;
        logic [0:11][7:0] b;
        bit               stall;
        int               exp_acc;
        int               exp_wr;
        bit               exp_done;
        bit               exp_err;
    } vec_t;
    logic clk = 0;
    logic reset = 1;
    logic cpu_reset, load_done, load_err;
    int total = 0, bad = 0, nwr = 0;
    logic prev_we = 0;
    logic [42:0] exp_q[$];
    vec_t vecs[6];
    boot_loader_if #(.ADDR_W(11)) bus();
    boot_loader #(.MEM_DEPTH(2048)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_err (load_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.mem_we) begin
            nwr++;
            chk("we_one_cycle", prev_we, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h", bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [42:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(e[42:32]));
                chk("wr_data", 64'(bus.mem_wdata), 64'(e[31:0]));
            end
        end
        prev_we = bus.mem_we;
    end
    task automatic chk_reset_vals();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err", load_err, 0);
    endtask
    function automatic vec_t mk(int len, logic [95:0] b, bit stall, int acc, int wr, bit done, bit err);
        vec_t v;
        v.len = len; v.b = b; v.stall = stall; v.exp_acc = acc;
        v.exp_wr = wr; v.exp_done = done; v.exp_err = err;
        return v;
    endfunction
    task automatic run_case(input vec_t v, input bit do_rst);
        int acc, n, nstart;
        bit ok;
        if (do_rst) begin
            reset = 1;
            bus.in_valid = 0;
            @(posedge clk);
            #1 chk_reset_vals();
            @(negedge clk);
            reset = 0;
        end
        n = int'({v.b[0], v.b[1]});
        acc = 0;
        nstart = nwr;
        for (int k = 0; k < v.len; k++) begin
            if (v.stall) begin
                bus.in_valid = 0;
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            bus.in_valid = 1;
            bus.in_data = v.b[k];
            ok = bus.in_ready;
            if (ok && k >= 5 && n <= 2048 && k - 2 < 4 * n && (k - 2) % 4 == 3)
                exp_q.push_back({11'((k - 2) / 4), v.b[k-3], v.b[k-2], v.b[k-1], v.b[k]});
            @(posedge clk);
            #1 bus.in_valid = 0;
            if (ok) begin
                acc++;
                if (acc == v.exp_acc) begin
                    chk("edge_load_done", load_done, v.exp_done);
                    chk("edge_load_err", load_err, v.exp_err);
                    chk("edge_cpu_reset", cpu_reset, 1);
                    @(posedge clk);
                    #1 chk("next_cpu_reset", cpu_reset, !v.exp_done);
                end
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("accepted", 64'(acc), 64'(v.exp_acc));
        chk("writes", 64'(nwr - nstart), 64'(v.exp_wr));
        chk("sb_empty", 64'(exp_q.size()), 0);
        chk("end_in_ready", bus.in_ready, 0);
        chk("end_load_done", load_done, v.exp_done);
        chk("end_load_err", load_err, v.exp_err);
        chk("end_cpu_reset", cpu_reset, !v.exp_done);
    endtask
    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        vecs[0] = mk(11, 96'h0002000000AA00000000AA00, 0, 11, 2, 1, 0);
        vecs[1] = mk(11, 96'h0002000000AA00000000AB00, 0, 11, 2, 0, 1);
        vecs[2] = mk(4,  96'h000000550000000000000000, 0, 3, 0, 1, 0);
        vecs[3] = mk(6,  96'h0801000000AA000000000000, 0, 2, 0, 0, 1);
        vecs[4] = mk(11, 96'h0002000000AA00000000AA00, 1, 11, 2, 1, 0);
        vecs[5] = mk(7,  96'h000112345678080000000000, 0, 7, 1, 1, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) run_case(vecs[i], 1);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1;
            bus.in_data = vecs[0].b[k];
            @(posedge clk);
            #1 bus.in_valid = 0;
            @(negedge clk);
        end
        #2 reset = 1;
        #1 chk_reset_vals();
        @(posedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        reset = 0;
        run_case(vecs[0], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
